dmaster_b2p_channel_adapter: RTL and testbench
==============================================

Name: dmaster_b2p_channel_adapter

Overview:
- Receive-side counterpart of the dmaster packet-to-byte channel adapter.
- Accepts a channel-tagged 8-bit Avalon-ST byte stream and forwards only beats whose channel matches CHANNEL_SEL, with the channel field stripped.
- Checks SOP/EOP framing and drops beats that arrive outside a packet.
- Sits between the byte-stream demux and the dmaster packet consumer. All outputs are registered (skid buffer) for timing closure.

Parameters:
- CHANNEL_SEL, 0: channel number forwarded; all other channels are consumed and discarded.
- CNT_W, 16: width of the saturating diagnostic counters.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_ready  out  1  upstream ready.
- in_valid  in  1  upstream valid.
- in_data  in  8  upstream byte.
- in_startofpacket  in  1  upstream SOP.
- in_endofpacket  in  1  upstream EOP.
- in_channel  in  8  upstream channel tag.
- out_ready  in  1  downstream ready.
- out_valid  out  1  downstream valid.
- out_data  out  8  downstream byte.
- out_startofpacket  out  1  downstream SOP.
- out_endofpacket  out  1  downstream EOP.
- drop_count  out  CNT_W  channel-mismatch beats discarded; saturating.
- orphan_count  out  CNT_W  matching-channel beats discarded for framing; saturating.
- frame_err  out  1  sticky; set on any framing violation.
- pkt_count  out  CNT_W  optional-feature port (see Optional Feature).

Behaviour:
- One clock; reset is synchronous, active-high. Port names: clk, reset.
- Reset values:
  - out_valid, out_startofpacket, out_endofpacket = 0; out_data = 0.
  - in_ready = 0 while reset is high.
  - Counters = 0; frame_err = 0; FSM = IDLE; skid entry empty.
- Reset mid-packet: all buffered beats are discarded silently (no counter increments) and the FSM returns to IDLE.
- Accept: a beat is taken when in_valid & in_ready.
  - in_ready = ~skid_valid & ~reset (registered source).
  - Mismatching-channel beats are accepted under the same rule; they never bypass backpressure.
- Buffering: output register plus one skid entry.
  - A forwardable beat loads the output register if it is empty, or drained this cycle (out_valid & out_ready) with the skid empty; otherwise it loads the skid.
  - When the output drains and the skid is valid, the skid moves to the output in the same cycle.
  - Latency: in-accept to out_valid = 1 cycle.
  - Throughput: 1 beat/cycle when out_ready is held high.
  - Output fields remain stable while out_valid & ~out_ready.
- Channel filter: in_channel != CHANNEL_SEL
  - Beat is discarded; drop_count += 1 (saturates at all-ones).
  - FSM is unaffected, even if the beat carries SOP/EOP.
- Framing FSM (matching-channel beats only):
  - IDLE, beat with SOP & EOP: forward; stay IDLE.
  - IDLE, beat with SOP & ~EOP: forward; go to IN_PKT.
  - IDLE, beat with ~SOP: orphan. Discard; orphan_count += 1; frame_err = 1; stay IDLE.
  - IN_PKT, beat with ~SOP & EOP: forward; go to IDLE.
  - IN_PKT, beat with ~SOP & ~EOP: forward; stay IN_PKT.
  - IN_PKT, beat with SOP (missing EOP on the previous packet): forward as the start of a new packet; frame_err = 1. Next state is IDLE if the beat also has EOP, else IN_PKT. The previous packet is left unterminated; orphan_count is unchanged.
- Counter behaviour:
  - Simultaneous increments to different counters are independent.
  - Saturated counters hold their value.
  - frame_err clears only on reset.
- out_channel does not exist; the channel is fully consumed.

Optional Feature:
- Macro: DMASTER_B2P_PKT_COUNT_EN.
- Defined: pkt_count increments by 1 (saturating) on each out_valid & out_ready & out_endofpacket handshake; resets to 0.
- Undefined: pkt_count is tied to 0 and no counter logic is generated. The port is present in both builds.

Test Plan:
- Basic forward: CHANNEL_SEL=0, out_ready=1; 4-beat packet ch0, data 0x11..0x14, SOP on beat 1, EOP on beat 4 -> out shows the same 4 bytes one cycle later with matching SOP/EOP; no counter changes; pkt_count=1 if the macro is enabled.
- Filter: interleave ch3 beats 0xA0..0xA2 with a ch0 packet 0x01,0x02 -> only 0x01,0x02 appear; drop_count=3.
- Backpressure: stream 8 beats 0x00..0x07 with out_ready toggled 1,0,0,1,... -> all 8 beats delivered in order with no loss or duplication; in_ready falls only when the skid is full; output held stable during stalls.
- Orphan: ch0 beat 0x55 with no SOP while in IDLE -> not forwarded; orphan_count=1; frame_err=1.
- Missing EOP: ch0 beats SOP 0x10, 0x11, then SOP+EOP 0x20 -> all 3 forwarded; frame_err=1; FSM ends in IDLE.
- Reset mid-packet: accept SOP 0x30 with out_ready=0, then pulse reset -> out_valid=0 and in_ready=0 during reset, in_ready=1 the cycle after; counters zero; a following ch0 beat without SOP counts as an orphan.

Source files
------------

// File: rtl/dmaster_b2p_channel_adapter.sv
// Receive-side channel adapter: filters a channel-tagged byte stream down to CHANNEL_SEL,
// checks SOP/EOP framing, and presents the result through an output register plus skid entry.
// Optional packet counter enabled by defining DMASTER_B2P_PKT_COUNT_EN.
module dmaster_b2p_channel_adapter #(
  parameter int unsigned CHANNEL_SEL = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             in_ready,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_startofpacket,
  input  logic             in_endofpacket,
  input  logic [7:0]       in_channel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] orphan_count,
  output logic             frame_err,
  output logic [CNT_W-1:0] pkt_count
);

  localparam logic [7:0] CHAN_SEL_B = 8'(CHANNEL_SEL);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic             skid_valid_q, skid_valid_d;
  logic [7:0]       skid_data_q, skid_data_d;
  logic             skid_sop_q, skid_sop_d;
  logic             skid_eop_q, skid_eop_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] orphan_q, orphan_d;
  logic             ferr_q, ferr_d;

  logic accept_s;
  logic chan_match_s;
  logic fwd_s;
  logic drain_s;

  // Accepting only while the skid is empty guarantees there is always room for the beat.
  assign in_ready     = ~skid_valid_q & ~reset;
  assign accept_s     = in_valid & in_ready;
  assign chan_match_s = (in_channel == CHAN_SEL_B);
  assign drain_s      = out_valid_q & out_ready;

  // Channel filter, framing FSM and diagnostic counters.
  always_comb begin
    state_d  = state_q;
    fwd_s    = 1'b0;
    drop_d   = drop_q;
    orphan_d = orphan_q;
    ferr_d   = ferr_q;
    if (accept_s) begin
      if (!chan_match_s) begin
        drop_d = sat_inc(drop_q);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_startofpacket) begin
              fwd_s   = 1'b1;
              state_d = in_endofpacket ? ST_IDLE : ST_IN_PKT;
            end else begin
              orphan_d = sat_inc(orphan_q);
              ferr_d   = 1'b1;
            end
          end
          ST_IN_PKT: begin
            fwd_s   = 1'b1;
            state_d = in_endofpacket ? ST_IDLE : ST_IN_PKT;
            if (in_startofpacket) begin
              ferr_d = 1'b1;
            end else begin
              ferr_d = ferr_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output register plus skid entry; the skid always drains ahead of any new beat.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    if (!out_valid_q || drain_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sop_d    = skid_sop_q;
        out_eop_d    = skid_eop_q;
        skid_valid_d = 1'b0;
      end else if (fwd_s) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_sop_d   = in_startofpacket;
        out_eop_d   = in_endofpacket;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (fwd_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_sop_d   = in_startofpacket;
        skid_eop_d   = in_endofpacket;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 8'h00;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      drop_q       <= '0;
      orphan_q     <= '0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
      drop_q       <= drop_d;
      orphan_q     <= orphan_d;
      ferr_q       <= ferr_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign drop_count        = drop_q;
  assign orphan_count      = orphan_q;
  assign frame_err         = ferr_q;

`ifdef DMASTER_B2P_PKT_COUNT_EN
  logic [CNT_W-1:0] pkt_q, pkt_d;

  // Completed packets leaving on the downstream interface.
  always_comb begin
    if (drain_s && out_eop_q) begin
      pkt_d = sat_inc(pkt_q);
    end else begin
      pkt_d = pkt_q;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_dmaster_b2p_channel_adapter.sv
// Directed bench with a queue-based reference model checked every cycle, plus literal checks.
module tb_dmaster_b2p_channel_adapter;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_ready;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_startofpacket;
  logic             in_endofpacket;
  logic [7:0]       in_channel;
  logic             out_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_startofpacket;
  logic             out_endofpacket;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] orphan_count;
  logic             frame_err;
  logic [CNT_W-1:0] pkt_count;

  dmaster_b2p_channel_adapter #(.CHANNEL_SEL(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_channel(in_channel), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .drop_count(drop_count),
    .orphan_count(orphan_count), .frame_err(frame_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  beat_t      mq[$];
  logic [7:0] got[$];
  int  m_drop, m_orph, m_pkt;
  bit  m_ferr, m_inpkt;
  int  n_total = 0;
  int  n_pass  = 0;
  bit  bp_mode = 1'b0;
  int  bp_idx  = 0;
  bit  bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit  saw_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int sat_add(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Reference model: a beat queue standing for whatever the adapter currently holds.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_drop = 0; m_orph = 0; m_pkt = 0; m_ferr = 1'b0; m_inpkt = 1'b0;
      end else begin
        int sz;
        bit acc;
        sz  = mq.size();
        acc = in_valid && (sz < 2);
        if (sz > 0 && out_ready) begin
          if (mq[0].e) m_pkt = sat_add(m_pkt);
          void'(mq.pop_front());
        end
        if (acc) begin
          if (in_channel != 8'd0) begin
            m_drop = sat_add(m_drop);
          end else if (!in_startofpacket && !m_inpkt) begin
            m_orph = sat_add(m_orph);
            m_ferr = 1'b1;
          end else begin
            beat_t b;
            if (in_startofpacket && m_inpkt) m_ferr = 1'b1;
            b.d = in_data; b.s = in_startofpacket; b.e = in_endofpacket;
            mq.push_back(b);
            m_inpkt = !in_endofpacket;
          end
        end
      end
    end
  end

  // Per-cycle comparison of DUT against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(mq[0].d));
        chk("out_sop", 32'(out_startofpacket), 32'(mq[0].s));
        chk("out_eop", 32'(out_endofpacket), 32'(mq[0].e));
      end
      chk("in_ready", 32'(in_ready), 32'((mq.size() < 2) && !reset));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("orphan_count", 32'(orphan_count), 32'(m_orph));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef DMASTER_B2P_PKT_COUNT_EN
      chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
`else
      chk("pkt_count", 32'(pkt_count), 32'd0);
`endif
      if (!reset && !in_ready) saw_stall = 1'b1;
      if (!reset && out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      out_ready = bp_pat[bp_idx % 4];
      bp_idx++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] ch, input logic [7:0] d, input logic s, input logic e);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_channel = ch; in_data = d; in_startofpacket = s; in_endofpacket = e;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 64);
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    step();
    got.delete();
  endtask

  task automatic chk_got(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(name, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_channel = 8'h00;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Basic forward
    send(8'd0, 8'h11, 1'b1, 1'b0);
    send(8'd0, 8'h12, 1'b0, 1'b0);
    send(8'd0, 8'h13, 1'b0, 1'b0);
    send(8'd0, 8'h14, 1'b0, 1'b1);
    idle(3);
    chk_got("fwd_data", '{8'h11, 8'h12, 8'h13, 8'h14});
    chk("fwd_drop", 32'(drop_count), 32'd0);
    chk("fwd_ferr", 32'(frame_err), 32'd0);
`ifdef DMASTER_B2P_PKT_COUNT_EN
    chk("fwd_pkt", 32'(pkt_count), 32'd1);
`else
    chk("fwd_pkt", 32'(pkt_count), 32'd0);
`endif

    // Channel filter
    do_reset();
    send(8'd3, 8'hA0, 1'b1, 1'b0);
    send(8'd0, 8'h01, 1'b1, 1'b0);
    send(8'd3, 8'hA1, 1'b0, 1'b0);
    send(8'd0, 8'h02, 1'b0, 1'b1);
    send(8'd3, 8'hA2, 1'b0, 1'b1);
    idle(3);
    chk_got("flt_data", '{8'h01, 8'h02});
    chk("flt_drop", 32'(drop_count), 32'd3);
    chk("flt_ferr", 32'(frame_err), 32'd0);

    // Backpressure
    do_reset();
    saw_stall = 1'b0;
    bp_idx = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(8'd0, 8'(i), 1'(i == 0), 1'(i == 7));
    idle(12);
    bp_mode = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk_got("bp_data", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
    chk("bp_stall_seen", 32'(saw_stall), 32'd1);

    // Orphan
    do_reset();
    send(8'd0, 8'h55, 1'b0, 1'b0);
    idle(2);
    chk("orph_count", 32'(orphan_count), 32'd1);
    chk("orph_ferr", 32'(frame_err), 32'd1);
    chk("orph_none_out", 32'(got.size()), 32'd0);

    // Missing EOP
    do_reset();
    send(8'd0, 8'h10, 1'b1, 1'b0);
    send(8'd0, 8'h11, 1'b0, 1'b0);
    send(8'd0, 8'h20, 1'b1, 1'b1);
    idle(3);
    chk_got("meop_data", '{8'h10, 8'h11, 8'h20});
    chk("meop_ferr", 32'(frame_err), 32'd1);
    chk("meop_orph", 32'(orphan_count), 32'd0);
    send(8'd0, 8'h66, 1'b0, 1'b0);
    idle(2);
    chk("meop_idle_orph", 32'(orphan_count), 32'd1);

    // Reset mid-packet
    do_reset();
    out_ready = 1'b0;
    send(8'd0, 8'h30, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_in_ready_rst", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("rmid_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_in_ready_after", 32'(in_ready), 32'd1);
    chk("rmid_drop", 32'(drop_count), 32'd0);
    chk("rmid_orph", 32'(orphan_count), 32'd0);
    out_ready = 1'b1;
    step();
    got.delete();
    send(8'd0, 8'h31, 1'b0, 1'b0);
    idle(2);
    chk("rmid_orphan_after", 32'(orphan_count), 32'd1);
    chk("rmid_none_out", 32'(got.size()), 32'd0);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 17; i++) send(8'd7, 8'(i), 1'b1, 1'b1);
    idle(2);
    chk("sat_drop", 32'(drop_count), 32'd15);
    chk("sat_ferr", 32'(frame_err), 32'd0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
